uart_cmd_ctrl: RTL and testbench
================================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4, number of controlled channels, legal range 1..16.
REQ-002 Parameter TXQ_DEPTH, default 4, response FIFO depth, power of two and at least 2.
REQ-003 Parameter TIMEOUT_CYC, default 100_000_000, clk cycles allowed between 'C' and its channel digit.
REQ-004 Port clk, in, 1, single clock for the whole block.
REQ-005 Port reset_n, in, 1, asynchronous active-low reset.
REQ-006 Port rx_req, in, 1, received byte valid; held high until acknowledged.
REQ-007 Port rx_data, in, 8, received byte.
REQ-008 Port rx_perr, in, 1, parity error flag for rx_data.
REQ-009 Port rx_ack, out, 1, one-cycle registered pulse that consumes the byte.
REQ-010 Port tx_send, out, 1, request to transmit tx_data.
REQ-011 Port tx_data, out, 8, byte to transmit; stable while tx_send=1.
REQ-012 Port tx_sent, in, 1, transmitter done flag.
REQ-013 Port start, out, NUM_CH, per-channel run enable.
REQ-014 Port read_write, out, 3*NUM_CH, packed per-channel mode; channel i occupies bits [3i+2:3i].
REQ-015 Port sel_ch, out, clog2(NUM_CH) (minimum 1), currently selected channel.

Function
REQ-016 A byte SHALL be accepted only when rx_req=1, rx_ack=0 and the FIFO is not full; acceptance SHALL raise rx_ack for exactly the next cycle. If the FIFO is full, acceptance SHALL wait and rx_ack SHALL stay low.
REQ-017 The FSM states SHALL be IDLE and GET_CH.
REQ-018 In IDLE, the commands SHALL apply to channel sel_ch as follows, with the queued response byte in parentheses:
- '0' sets start (queue 'A')
- '1' clears start (queue 'B')
- '2' sets mode 1 (queue 'C')
- '3' sets mode 0 (queue 'D')
- '4' sets mode 2 (queue 'E')
REQ-019 In IDLE, 'G' SHALL set all start bits (queue 'G'), and 'H' SHALL clear all start bits (queue 'H').
REQ-020 In IDLE, 'S' SHALL queue one byte equal to 8'h30 + {start[sel_ch], read_write[sel_ch][1:0]}.
REQ-021 In IDLE, 'C' SHALL move the FSM to GET_CH and queue nothing. Any other byte SHALL queue '?' and change no state.
REQ-022 In GET_CH, the next byte SHALL be interpreted as a channel digit:
- ASCII hex digit '0'-'9' or 'A'-'F' with value < NUM_CH: load sel_ch, queue 'K'
- any other byte: sel_ch unchanged, queue '?'
- in both cases, return to IDLE
REQ-023 In GET_CH, the timeout counter SHALL clear on entry and increment every cycle. When it reaches TIMEOUT_CYC-1, the block SHALL queue '?' (waiting for FIFO space if the FIFO is full) and return to IDLE.
REQ-024 Any byte accepted with rx_perr=1 SHALL queue '!', change no register, and force the FSM to IDLE.
REQ-025 Register updates SHALL take effect on the clock edge that raises rx_ack.
REQ-026 Each response SHALL be pushed into the FIFO in that same cycle.
REQ-027 The TX side SHALL run a four-phase handshake:
- when the FIFO is non-empty and both tx_send and tx_sent are 0: pop the FIFO head into tx_data and raise tx_send
- hold tx_send high until tx_sent=1, then drop it
- do not start the next byte until tx_sent=0
REQ-028 A FIFO push and pop in the same cycle SHALL leave the count unchanged, including when the FIFO is full. The FIFO pointers SHALL wrap modulo TXQ_DEPTH.
REQ-029 Responses SHALL be transmitted in command order. No response SHALL ever be dropped.

Reset
REQ-030 On reset_n=0, the following SHALL be cleared immediately:
- start, read_write, sel_ch, rx_ack, tx_send, tx_data
- FIFO contents and count
- timeout counter
- FSM, which returns to IDLE
REQ-031 A reset mid-transmission or in GET_CH SHALL abandon the pending byte or command without emitting a response.

Structure
REQ-032 Package uart_cmd_pkg SHALL hold:
- command byte constants
- response byte constants
- mode encodings: MODE_READ=0, MODE_WRITE=1, MODE_RW=2
- the FSM state enum
REQ-033 The response queue SHALL be a separate sub-module, uart_cmd_fifo, parametrised by DEPTH and WIDTH=8.

Verification
REQ-034 Send 'C','2' then '0' with NUM_CH=4 -> responses 'K','A'; start=4'b0100; sel_ch=2.
REQ-035 Send '4' then 'S' on channel 0 -> responses 'E' then 8'h32; read_write[2:0]=2.
REQ-036 Send 'C','9' with NUM_CH=4 -> response '?'; sel_ch unchanged. Send 'C' then wait TIMEOUT_CYC cycles (set to 16) -> response '?'; FSM back in IDLE.
REQ-037 Hold tx_sent low while feeding 6 valid commands with TXQ_DEPTH=4 -> only 4 rx_ack pulses until the TX side drains. Then all 6 responses arrive in order, none lost.
REQ-038 Send byte '0' with rx_perr=1 -> response '!'; start unchanged.
REQ-039 Assert reset_n low during tx_send=1 after 'G' -> all outputs 0 at once; no further tx_send after release.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants, mode encodings, FSM state type and the hex-digit decoder
// used by the UART command controller.
package uart_cmd_pkg;

  // Command bytes received from the host.
  localparam logic [7:0] CMD_SET_START  = 8'h30; // '0'
  localparam logic [7:0] CMD_CLR_START  = 8'h31; // '1'
  localparam logic [7:0] CMD_MODE_WRITE = 8'h32; // '2'
  localparam logic [7:0] CMD_MODE_READ  = 8'h33; // '3'
  localparam logic [7:0] CMD_MODE_RW    = 8'h34; // '4'
  localparam logic [7:0] CMD_ALL_START  = 8'h47; // 'G'
  localparam logic [7:0] CMD_ALL_STOP   = 8'h48; // 'H'
  localparam logic [7:0] CMD_STATUS     = 8'h53; // 'S'
  localparam logic [7:0] CMD_SELECT     = 8'h43; // 'C'

  // Response bytes sent back to the host.
  localparam logic [7:0] RSP_SET_START  = 8'h41; // 'A'
  localparam logic [7:0] RSP_CLR_START  = 8'h42; // 'B'
  localparam logic [7:0] RSP_MODE_WRITE = 8'h43; // 'C'
  localparam logic [7:0] RSP_MODE_READ  = 8'h44; // 'D'
  localparam logic [7:0] RSP_MODE_RW    = 8'h45; // 'E'
  localparam logic [7:0] RSP_ALL_START  = 8'h47; // 'G'
  localparam logic [7:0] RSP_ALL_STOP   = 8'h48; // 'H'
  localparam logic [7:0] RSP_SEL_OK     = 8'h4B; // 'K'
  localparam logic [7:0] RSP_BAD        = 8'h3F; // '?'
  localparam logic [7:0] RSP_PARITY     = 8'h21; // '!'
  localparam logic [7:0] RSP_STATUS_BASE = 8'h30;

  // Per-channel mode encodings (3 bits per channel on read_write).
  localparam logic [2:0] MODE_READ  = 3'd0;
  localparam logic [2:0] MODE_WRITE = 3'd1;
  localparam logic [2:0] MODE_RW    = 3'd2;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    GET_CH = 1'b1
  } state_e;

  // Returns {valid, value}; only '0'-'9' and upper-case 'A'-'F' are digits.
  function automatic logic [4:0] hex_digit(input logic [7:0] b);
    logic [4:0] res;
    res = 5'd0;
    if (b >= 8'h30 && b <= 8'h39) begin
      res = {1'b1, 4'(b - 8'h30)};
    end else if (b >= 8'h41 && b <= 8'h46) begin
      res = {1'b1, 4'(b - 8'h37)};
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_cmd_fifo.sv
// Small response FIFO with a show-ahead head. Simultaneous push and pop is
// allowed even when full: the pop frees the slot the push fills.
module uart_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_CNT);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign pop_data  = r_mem[r_rd_ptr];

  // Storage write; contents are cleared on reset so nothing stale survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Byte-oriented command interpreter: decodes host bytes into per-channel
// start/mode registers, queues a response per command and ships responses
// out through a four-phase transmitter handshake.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int TXQ_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_req,
  input  logic [7:0]            rx_data,
  input  logic                  rx_perr,
  output logic                  rx_ack,
  output logic                  tx_send,
  output logic [7:0]            tx_data,
  input  logic                  tx_sent,
  output logic [NUM_CH-1:0]     start,
  output logic [3*NUM_CH-1:0]   read_write,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sel_ch
);

  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e              r_state;
  state_e              w_state_next;
  logic [NUM_CH-1:0]   r_start;
  logic [NUM_CH-1:0]   w_start_next;
  logic [3*NUM_CH-1:0] r_rw;
  logic [3*NUM_CH-1:0] w_rw_next;
  logic [SW-1:0]       r_sel;
  logic [SW-1:0]       w_sel_next;
  logic                r_rx_ack;
  logic [TW-1:0]       r_tout;
  logic                r_tx_send;
  logic [7:0]          r_tx_data;

  logic                w_accept;
  logic                w_timeout;
  logic                w_push;
  logic [7:0]          w_push_data;
  logic                w_pop;
  logic [7:0]          w_head;
  logic                w_full;
  logic                w_empty;
  logic [4:0]          w_hex;
  int                  w_sel_idx;

  assign rx_ack     = r_rx_ack;
  assign tx_send    = r_tx_send;
  assign tx_data    = r_tx_data;
  assign start      = r_start;
  assign read_write = r_rw;
  assign sel_ch     = r_sel;

  // A byte is taken only when the FIFO can hold whatever it produces.
  assign w_accept  = rx_req && !r_rx_ack && !w_full;
  // The timeout holds at its last count until the FIFO has room for '?'.
  assign w_timeout = (r_state == GET_CH) && (r_tout == TO_LAST) && !w_full;
  assign w_hex     = hex_digit(rx_data);
  assign w_sel_idx = int'(r_sel);
  // Start the next byte only once the transmitter has released tx_sent.
  assign w_pop     = !r_tx_send && !tx_sent && !w_empty;

  // Next-state and register updates; a received byte outranks the timeout.
  always_comb begin
    w_state_next = r_state;
    w_start_next = r_start;
    w_rw_next    = r_rw;
    w_sel_next   = r_sel;
    w_push       = 1'b0;
    w_push_data  = 8'h00;
    if (w_accept) begin
      if (rx_perr) begin
        w_push       = 1'b1;
        w_push_data  = RSP_PARITY;
        w_state_next = IDLE;
      end else if (r_state == GET_CH) begin
        w_push       = 1'b1;
        w_state_next = IDLE;
        if (w_hex[4] && (int'(w_hex[3:0]) < NUM_CH)) begin
          w_sel_next  = SW'(w_hex[3:0]);
          w_push_data = RSP_SEL_OK;
        end else begin
          w_push_data = RSP_BAD;
        end
      end else begin
        w_push = 1'b1;
        case (rx_data)
          CMD_SET_START: begin
            w_start_next[w_sel_idx] = 1'b1;
            w_push_data = RSP_SET_START;
          end
          CMD_CLR_START: begin
            w_start_next[w_sel_idx] = 1'b0;
            w_push_data = RSP_CLR_START;
          end
          CMD_MODE_WRITE: begin
            w_rw_next[w_sel_idx*3 +: 3] = MODE_WRITE;
            w_push_data = RSP_MODE_WRITE;
          end
          CMD_MODE_READ: begin
            w_rw_next[w_sel_idx*3 +: 3] = MODE_READ;
            w_push_data = RSP_MODE_READ;
          end
          CMD_MODE_RW: begin
            w_rw_next[w_sel_idx*3 +: 3] = MODE_RW;
            w_push_data = RSP_MODE_RW;
          end
          CMD_ALL_START: begin
            w_start_next = '1;
            w_push_data  = RSP_ALL_START;
          end
          CMD_ALL_STOP: begin
            w_start_next = '0;
            w_push_data  = RSP_ALL_STOP;
          end
          CMD_STATUS: begin
            w_push_data = RSP_STATUS_BASE +
                          {5'd0, r_start[w_sel_idx], r_rw[w_sel_idx*3 +: 2]};
          end
          CMD_SELECT: begin
            w_push       = 1'b0;
            w_state_next = GET_CH;
          end
          default: begin
            w_push_data = RSP_BAD;
          end
        endcase
      end
    end else if (w_timeout) begin
      w_push       = 1'b1;
      w_push_data  = RSP_BAD;
      w_state_next = IDLE;
    end
  end

  // Control registers, FSM state and the one-cycle acknowledge pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_start  <= '0;
      r_rw     <= '0;
      r_sel    <= '0;
      r_rx_ack <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_start  <= w_start_next;
      r_rw     <= w_rw_next;
      r_sel    <= w_sel_next;
      r_rx_ack <= w_accept;
    end
  end

  // Channel-digit timeout: zero outside GET_CH, saturates at its last count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tout <= '0;
    end else if (r_state != GET_CH) begin
      r_tout <= '0;
    end else if (r_tout != TO_LAST) begin
      r_tout <= r_tout + TW'(1);
    end
  end

  // Four-phase transmit handshake: load and raise, hold until tx_sent, drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_send <= 1'b0;
      r_tx_data <= 8'h00;
    end else if (w_pop) begin
      r_tx_send <= 1'b1;
      r_tx_data <= w_head;
    end else if (r_tx_send && tx_sent) begin
      r_tx_send <= 1'b0;
    end
  end

  uart_cmd_fifo #(
    .DEPTH (TXQ_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: stimulus pushes expected responses into a
// queue, an independent transmitter model pops and compares each sent byte.
module tb_uart_cmd_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_req;
  logic [7:0]  rx_data;
  logic        rx_perr;
  logic        rx_ack;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        tx_sent;
  logic [3:0]  start;
  logic [11:0] read_write;
  logic [1:0]  sel_ch;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  logic [7:0] exp_q[$];
  bit tx_block = 1'b0;   // hold tx_sent high so nothing may start
  bit tx_stall = 1'b0;   // never answer tx_send

  uart_cmd_ctrl #(
    .NUM_CH      (4),
    .TXQ_DEPTH   (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_req     (rx_req),
    .rx_data    (rx_data),
    .rx_perr    (rx_perr),
    .rx_ack     (rx_ack),
    .tx_send    (tx_send),
    .tx_data    (tx_data),
    .tx_sent    (tx_sent),
    .start      (start),
    .read_write (read_write),
    .sel_ch     (sel_ch)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Acknowledge pulse counter.
  always @(negedge clk) begin
    if (rx_ack) ack_cnt++;
  end

  // Transmitter model and scoreboard monitor.
  initial begin
    logic [7:0] e;
    tx_sent = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        tx_sent = 1'b0;
      end else if (tx_stall) begin
        // leave the handshake hanging
      end else if (tx_block) begin
        tx_sent = 1'b1;
      end else if (tx_send && !tx_sent) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got 0x%0h expected no byte", tx_data);
        end else begin
          e = exp_q.pop_front();
          $display("tx byte 0x%0h expected 0x%0h", tx_data, e);
          check("tx_byte", 32'(tx_data), 32'(e));
        end
        tx_sent = 1'b1;
      end else if (!tx_send && tx_sent) begin
        tx_sent = 1'b0;
      end
    end
  end

  // Present one byte and wait for its acknowledge; optionally expect a response.
  task automatic send_byte(input logic [7:0] b, input logic perr,
                           input bit has_rsp, input logic [7:0] rsp);
    bit ok;
    if (has_rsp) exp_q.push_back(rsp);
    $display("rx byte 0x%0h perr %0d", b, perr);
    rx_data = b;
    rx_perr = perr;
    rx_req  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rx_ack) begin
        ok = 1'b1;
        break;
      end
    end
    rx_req  = 1'b0;
    rx_perr = 1'b0;
    check("rx_ack_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tx_send && !tx_sent) begin
        ok = 1'b1;
        break;
      end
    end
    check("drained", 32'(ok), 32'd1);
  endtask

  initial begin
    int base;
    int lat;
    int rises;
    reset_n = 1'b0;
    rx_req  = 1'b0;
    rx_data = 8'h00;
    rx_perr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start", 32'(start), 32'd0);
    check("rst_rw", 32'(read_write), 32'd0);
    check("rst_sel", 32'(sel_ch), 32'd0);
    check("rst_ack", 32'(rx_ack), 32'd0);
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Select channel 2 and start it.
    send_byte("C", 1'b0, 1'b0, 8'h00);
    send_byte("2", 1'b0, 1'b1, "K");
    check("sel_ch2", 32'(sel_ch), 32'd2);
    send_byte("0", 1'b0, 1'b1, "A");
    check("start_ch2", 32'(start), 32'h4);

    // Channel 0: mode 2 and status readback.
    send_byte("C", 1'b0, 1'b0, 8'h00);
    send_byte("0", 1'b0, 1'b1, "K");
    send_byte("4", 1'b0, 1'b1, "E");
    send_byte("S", 1'b0, 1'b1, 8'h32);
    check("rw_ch0_rw", 32'(read_write[2:0]), 32'd2);
    send_byte("0", 1'b0, 1'b1, "A");
    send_byte("S", 1'b0, 1'b1, 8'h36);
    send_byte("3", 1'b0, 1'b1, "D");
    send_byte("1", 1'b0, 1'b1, "B");
    send_byte("S", 1'b0, 1'b1, 8'h30);
    send_byte("G", 1'b0, 1'b1, "G");
    check("all_start", 32'(start), 32'hF);
    send_byte("H", 1'b0, 1'b1, "H");
    check("all_stop", 32'(start), 32'h0);
    send_byte("Z", 1'b0, 1'b1, "?");

    // Channel 3 write mode, then out-of-range selects.
    send_byte("C", 1'b0, 1'b0, 8'h00);
    send_byte("3", 1'b0, 1'b1, "K");
    send_byte("2", 1'b0, 1'b1, "C");
    check("rw_ch3_write", 32'(read_write[11:9]), 32'd1);
    send_byte("C", 1'b0, 1'b0, 8'h00);
    send_byte("9", 1'b0, 1'b1, "?");
    check("sel_after_9", 32'(sel_ch), 32'd3);
    send_byte("C", 1'b0, 1'b0, 8'h00);
    send_byte("F", 1'b0, 1'b1, "?");
    check("sel_after_F", 32'(sel_ch), 32'd3);
    wait_idle();

    // Channel-digit timeout: '?' appears 16 GET_CH cycles after 'C'.
    send_byte("C", 1'b0, 1'b1, "?");
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (tx_send) begin
        lat = i;
        break;
      end
    end
    check("timeout_latency", 32'(lat), 32'd17);
    wait_idle();
    send_byte("0", 1'b0, 1'b1, "A");   // an IDLE command, not a channel digit
    check("idle_after_timeout", 32'(start), 32'h8);
    check("sel_after_timeout", 32'(sel_ch), 32'd3);
    wait_idle();

    // Backpressure: transmitter blocked, only four bytes fit in the queue.
    tx_block = 1'b1;
    repeat (3) @(negedge clk);
    base = ack_cnt;
    fork
      begin
        send_byte("0", 1'b0, 1'b1, "A");
        send_byte("1", 1'b0, 1'b1, "B");
        send_byte("G", 1'b0, 1'b1, "G");
        send_byte("H", 1'b0, 1'b1, "H");
        send_byte("S", 1'b0, 1'b1, 8'h31);
        send_byte("Z", 1'b0, 1'b1, "?");
      end
      begin
        repeat (30) @(negedge clk);
        #1;
        check("acks_while_blocked", 32'(ack_cnt - base), 32'd4);
        tx_block = 1'b0;
      end
    join
    wait_idle();
    check("acks_total", 32'(ack_cnt - base), 32'd6);

    // Parity errors in IDLE and in GET_CH.
    send_byte("0", 1'b1, 1'b1, "!");
    check("perr_start", 32'(start), 32'h0);
    send_byte("C", 1'b0, 1'b0, 8'h00);
    send_byte("1", 1'b1, 1'b1, "!");
    check("perr_sel", 32'(sel_ch), 32'd3);
    send_byte("0", 1'b0, 1'b1, "A");
    check("idle_after_perr", 32'(start), 32'h8);
    wait_idle();

    // Reset while a response is in flight.
    tx_stall = 1'b1;
    send_byte("G", 1'b0, 1'b0, 8'h00);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (tx_send) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check("tx_send_before_reset", 32'(tx_send), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_start", 32'(start), 32'd0);
    check("mid_rst_rw", 32'(read_write), 32'd0);
    check("mid_rst_sel", 32'(sel_ch), 32'd0);
    check("mid_rst_ack", 32'(rx_ack), 32'd0);
    check("mid_rst_tx_send", 32'(tx_send), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    tx_stall = 1'b0;
    rises = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_send) rises++;
    end
    check("no_tx_after_reset", 32'(rises), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
